// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared states, opcode/funct/ALU encodings and per-state control table for multicycle_ctrl.
// MCTRL_ILLEGAL_TRAP_EN routes unknown opcodes to a sticky HALT state that raises illegal.
package mctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;
  typedef enum logic [1:0] {AOP_NONE, AOP_ADD, AOP_SUB, AOP_FUNCT} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam state_t ILL_NEXT = TRAP_EN ? HALT : FETCH;
  typedef struct packed {
    logic fetch, mem_req, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    aluop_t aluop;
    logic pcwrite, branch, illegal;
  } ctl_t;
  // fetch marks the state whose irwrite/pcwrite fire on mem_ready
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.fetch = 1'b1; c.mem_req = 1'b1; c.alusrcb = SRCB_4; c.aluop = AOP_ADD; c.pcsrc = PC_ALU; end
      DECODE:  begin c.alusrcb = SRCB_IMMSH; c.aluop = AOP_ADD; end
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluop = AOP_ADD; end
      MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.alusrcb = SRCB_B; c.aluop = AOP_FUNCT; end
      ALUWB:   begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BRANCH:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_B; c.aluop = AOP_SUB; c.pcsrc = PC_ALUOUT; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluop = AOP_ADD; end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = PC_JUMP; c.pcwrite = 1'b1; end
      HALT:    c.illegal = TRAP_EN;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: decode inputs and control outputs between the control FSM and the datapath.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0] op, funct;
  logic zero, mem_ready;
  logic mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  logic [CNT_W-1:0] instret;
  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal, state_o, instret
  );
  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca,
           alusrcb, pcsrc, alucontrol, pcen, illegal, state_o, instret
  );
endinterface

// File: rtl/mctrl_aludec.sv
// mctrl_aludec: maps the FSM's ALU operation class and the R-type funct field to alucontrol.
module mctrl_aludec
  import mctrl_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);
  logic [2:0] w_fn_alu;
  assign w_fn_alu = i_funct == FN_SUB ? ALU_SUB :
                    i_funct == FN_AND ? ALU_AND :
                    i_funct == FN_OR  ? ALU_OR  :
                    i_funct == FN_SLT ? ALU_SLT : ALU_ADD;
  assign o_alucontrol = i_aluop == AOP_ADD   ? ALU_ADD :
                        i_aluop == AOP_SUB   ? ALU_SUB :
                        i_aluop == AOP_FUNCT ? w_fn_alu : 3'b000;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/writeback sequencer with retired-instruction counter.
// Build with MCTRL_ILLEGAL_TRAP_EN to trap unknown opcodes in HALT.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master bus
);
  state_t r_state, w_next;
  ctl_t r_ctl;
  logic [CNT_W-1:0] r_instret;
  logic w_retire, w_fetch_go;
  logic [2:0] w_alucontrol;
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = bus.mem_ready ? DECODE : FETCH;
      DECODE:  w_next = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                        bus.op == OP_RTYPE ? EXECUTE :
                        bus.op == OP_BEQ   ? BRANCH :
                        bus.op == OP_ADDI  ? ADDIEX :
                        bus.op == OP_J     ? JUMP : ILL_NEXT;
      MEMADR:  w_next = bus.op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   w_next = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   w_next = bus.mem_ready ? FETCH : MEMWR;
      EXECUTE: w_next = ALUWB;
      ADDIEX:  w_next = ADDIWB;
      HALT:    w_next = HALT;
      default: w_next = FETCH;
    endcase
  end
  // DECODE->FETCH on a NOP'd illegal opcode is deliberately not a retirement
  assign w_retire = w_next == FETCH && r_state inside {MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP};
  // the Moore control word is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= FETCH;
      r_ctl     <= ctl_of(FETCH);
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= ctl_of(w_next);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  mctrl_aludec u_aludec (
    .i_aluop      (r_ctl.aluop),
    .i_funct      (bus.funct),
    .o_alucontrol (w_alucontrol)
  );
  assign w_fetch_go     = r_ctl.fetch & bus.mem_ready;
  // strobes are forced low for as long as reset is held
  assign bus.mem_req    = reset & r_ctl.mem_req;
  assign bus.memwrite   = reset & r_ctl.memwrite;
  assign bus.irwrite    = reset & w_fetch_go;
  assign bus.regwrite   = reset & r_ctl.regwrite;
  assign bus.pcen       = reset & (r_ctl.pcwrite | w_fetch_go | (r_ctl.branch & bus.zero));
  assign bus.iord       = r_ctl.iord;
  assign bus.regdst     = r_ctl.regdst;
  assign bus.memtoreg   = r_ctl.memtoreg;
  assign bus.alusrca    = r_ctl.alusrca;
  assign bus.alusrcb    = r_ctl.alusrcb;
  assign bus.pcsrc      = r_ctl.pcsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.illegal    = r_ctl.illegal;
  assign bus.state_o    = r_state;
  assign bus.instret    = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; expected per-cycle control outputs are queued and compared each cycle.
module tb_multicycle_ctrl;
  import mctrl_pkg::*;
  typedef struct packed {
    logic [3:0] st;
    logic mem_req, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu;
    logic pcen, illegal;
    logic [31:0] instret;
  } obs_t;
  typedef struct packed {
    logic [5:0] op, fn;
    logic mr, z;
    obs_t e;
  } item_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] e_instret = '0;
  item_t q[$];
  multicycle_ctrl_if #(.CNT_W(32)) bus ();
  multicycle_ctrl #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t moore(state_t st);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      FETCH:   begin o.mem_req = 1; o.alusrcb = 2'b01; o.alu = 3'b010; end
      DECODE:  begin o.alusrcb = 2'b11; o.alu = 3'b010; end
      MEMADR:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alu = 3'b010; end
      MEMRD:   begin o.mem_req = 1; o.iord = 1; end
      MEMWB:   begin o.regwrite = 1; o.memtoreg = 1; end
      MEMWR:   begin o.mem_req = 1; o.iord = 1; o.memwrite = 1; end
      EXECUTE: o.alusrca = 1;
      ALUWB:   begin o.regwrite = 1; o.regdst = 1; end
      BRANCH:  begin o.alusrca = 1; o.alu = 3'b110; o.pcsrc = 2'b01; end
      ADDIEX:  begin o.alusrca = 1; o.alusrcb = 2'b10; o.alu = 3'b010; end
      ADDIWB:  o.regwrite = 1;
      JUMP:    o.pcsrc = 2'b10;
      HALT:    o.illegal = 1;
      default: o = '0;
    endcase
    return o;
  endfunction
  function automatic logic [2:0] fn_alu(logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction
  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state_o; o.mem_req = bus.mem_req; o.memwrite = bus.memwrite; o.iord = bus.iord;
    o.irwrite = bus.irwrite; o.regwrite = bus.regwrite; o.regdst = bus.regdst; o.memtoreg = bus.memtoreg;
    o.alusrca = bus.alusrca; o.alusrcb = bus.alusrcb; o.pcsrc = bus.pcsrc; o.alu = bus.alucontrol;
    o.pcen = bus.pcen; o.illegal = bus.illegal; o.instret = bus.instret;
    return o;
  endfunction
  task automatic push(input state_t st, input logic [5:0] op, input logic [5:0] fn, input logic mr, input logic z);
    item_t it;
    it.op = op; it.fn = fn; it.mr = mr; it.z = z;
    it.e = moore(st);
    it.e.irwrite = st == FETCH && mr;
    it.e.pcen = (st == FETCH && mr) || st == JUMP || (st == BRANCH && z);
    if (st == EXECUTE) it.e.alu = fn_alu(fn);
    it.e.instret = e_instret;
    q.push_back(it);
    if (st inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP} || (st == MEMWR && mr)) e_instret++;
  endtask
  task automatic step(input item_t it, output obs_t o);
    @(posedge clk);
    #1;
    bus.op = it.op; bus.funct = it.fn; bus.mem_ready = it.mr; bus.zero = it.z;
    @(negedge clk);
    o = sample();
  endtask
  task automatic test_reset();
    obs_t o, e;
    #12;
    e = moore(FETCH); e.mem_req = 0;
    o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_held: got %h exp %h", o, e); end
    @(negedge clk); reset = 1'b1;
    #1; o = sample(); e = moore(FETCH); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_release: got %h exp %h", o, e); end
  endtask
  task automatic test_lw();
    item_t it; obs_t o;
    push(FETCH, 6'b100011, 6'd0, 1, 0); push(DECODE, 6'b100011, 6'd0, 1, 0);
    push(MEMADR, 6'b100011, 6'd0, 1, 0); push(MEMRD, 6'b100011, 6'd0, 1, 0);
    push(MEMWB, 6'b100011, 6'd0, 1, 0);
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL lw st%0d: got %h exp %h", it.e.st, o, it.e); end
    end
  endtask
  task automatic test_sw_stall();
    item_t it; obs_t o;
    push(FETCH, 6'b101011, 6'd0, 1, 0); push(DECODE, 6'b101011, 6'd0, 1, 0);
    push(MEMADR, 6'b101011, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) push(MEMWR, 6'b101011, 6'd0, 0, 0);
    push(MEMWR, 6'b101011, 6'd0, 1, 0);
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL sw_stall st%0d: got %h exp %h", it.e.st, o, it.e); end
    end
  endtask
  task automatic test_beq();
    item_t it; obs_t o;
    for (int z = 1; z >= 0; z--) begin
      push(FETCH, 6'b000100, 6'd0, 1, 1'(z)); push(DECODE, 6'b000100, 6'd0, 1, 1'(z));
      push(BRANCH, 6'b000100, 6'd0, 1, 1'(z));
    end
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL beq z%0d st%0d: got %h exp %h", it.z, it.e.st, o, it.e); end
    end
  endtask
  task automatic test_rtype();
    item_t it; obs_t o;
    logic [5:0] fns [3] = '{6'b101010, 6'b100010, 6'b111111};
    foreach (fns[k]) begin
      push(FETCH, 6'b000000, fns[k], 1, 0); push(DECODE, 6'b000000, fns[k], 1, 0);
      push(EXECUTE, 6'b000000, fns[k], 1, 0); push(ALUWB, 6'b000000, fns[k], 1, 0);
    end
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL rtype fn%b st%0d: got %h exp %h", it.fn, it.e.st, o, it.e); end
    end
  endtask
  task automatic test_back_to_back();
    item_t it; obs_t o;
    push(FETCH, 6'b001000, 6'd0, 0, 0); push(FETCH, 6'b001000, 6'd0, 1, 0);
    push(DECODE, 6'b001000, 6'd0, 1, 0); push(ADDIEX, 6'b001000, 6'd0, 1, 0);
    push(ADDIWB, 6'b001000, 6'd0, 1, 0);
    push(FETCH, 6'b000010, 6'd0, 1, 0); push(DECODE, 6'b000010, 6'd0, 1, 0);
    push(JUMP, 6'b000010, 6'd0, 0, 0);
    push(FETCH, 6'b000000, 6'b100100, 1, 0); push(DECODE, 6'b000000, 6'b100100, 1, 0);
    push(EXECUTE, 6'b000000, 6'b100100, 1, 0); push(ALUWB, 6'b000000, 6'b100100, 1, 0);
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL b2b st%0d: got %h exp %h", it.e.st, o, it.e); end
    end
  endtask
  task automatic test_reset_mid();
    item_t it; obs_t o, e;
    push(FETCH, 6'b101011, 6'd0, 1, 0); push(DECODE, 6'b101011, 6'd0, 1, 0);
    push(MEMADR, 6'b101011, 6'd0, 1, 0); push(MEMWR, 6'b101011, 6'd0, 0, 0);
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL reset_mid st%0d: got %h exp %h", it.e.st, o, it.e); end
    end
    #2; reset = 1'b0;
    #1; o = sample(); e = moore(FETCH); e.mem_req = 0; e.instret = 0; n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_mid_assert: got %h exp %h", o, e); end
    @(posedge clk); #1; o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_mid_held: got %h exp %h", o, e); end
    @(negedge clk); reset = 1'b1; e_instret = '0;
    #1; o = sample(); e = moore(FETCH); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL reset_mid_release: got %h exp %h", o, e); end
  endtask
  task automatic test_illegal();
    item_t it; obs_t o;
    state_t after;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    after = HALT;
`else
    after = FETCH;
`endif
    push(FETCH, 6'b000010, 6'd0, 1, 0); push(DECODE, 6'b000010, 6'd0, 1, 0);
    push(JUMP, 6'b000010, 6'd0, 1, 0);
    push(FETCH, 6'b111111, 6'd0, 1, 1); push(DECODE, 6'b111111, 6'd0, 1, 1);
    push(after, 6'b111111, 6'd0, 0, 1);
    push(after, 6'b111111, 6'd0, 1, 1);
    if (after == HALT) push(HALT, 6'b100011, 6'd0, 1, 1);
    else push(DECODE, 6'b111111, 6'd0, 1, 1);
    while (q.size() > 0) begin
      it = q.pop_front(); step(it, o); n_cmp++;
      if (o !== it.e) begin n_err++; $display("FAIL illegal st%0d: got %h exp %h", it.e.st, o, it.e); end
    end
  endtask
  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_beq();
    test_rtype();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
